// File: rtl/tx_symbol_sequencer.sv
// ---------------------------------------------------------------------------
// tx_symbol_sequencer
//
// Symbol-rate sequencer feeding the 21-tap pulse-shaping filter. Accepts
// 2-bit 4-ASK symbols over valid/ready, maps each to an 18-bit signed 1s17
// level and zero-stuffs to OSR samples per symbol so the filter receives one
// sample every clk. On stop, the current symbol period completes, the filter
// is flushed with FLUSH_LEN zeros and done pulses.
//
// Parameters:
//   OSR        clk cycles per symbol (2..16)
//   FLUSH_LEN  zero samples driven after the last symbol period
//   LVL_HI     magnitude of the outer level (1s17)
//   LVL_LO     magnitude of the inner level (1s17)
//
// Ports:
//   clk          in   system clock, posedge
//   reset        in   synchronous, active-high
//   start        in   single-cycle request to begin transmission
//   stop         in   single-cycle request to end transmission
//   sym_in       in   [1:0] symbol: 00 -HI, 01 -LO, 10 +LO, 11 +HI
//   sym_valid    in   sym_in valid
//   sym_ready    out  symbol accepted this cycle (RUN and phase 0)
//   x_out        out  [17:0] signed registered sample to filter
//   sym_strobe   out  registered, high when x_out carries a symbol level
//   busy         out  state is RUN or FLUSH
//   done         out  one-cycle pulse when the flush completes
//   underrun     out  sticky, a symbol slot passed without a valid symbol
//   underrun_cnt out  [7:0] saturating underrun slot count
//
// Build option:
//   TX_UNDERRUN_CNT_EN  when defined, underrun_cnt is a live saturating
//                       counter; otherwise it is tied to zero. The sticky
//                       underrun flag exists in both builds.
// ---------------------------------------------------------------------------
module tx_symbol_sequencer #(
    parameter int OSR       = 4,
    parameter int FLUSH_LEN = 23,
    parameter int LVL_HI    = 98304,
    parameter int LVL_LO    = 32768
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         sym_in,
    input  logic               sym_valid,
    output logic               sym_ready,
    output logic signed [17:0] x_out,
    output logic               sym_strobe,
    output logic               busy,
    output logic               done,
    output logic               underrun,
    output logic [7:0]         underrun_cnt
);

    localparam int PW = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

    localparam logic [PW-1:0] PHASE_LAST = PW'(OSR - 1);
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_LEN - 1);

    localparam logic signed [17:0] LEVEL_NEG_HI = 18'(-LVL_HI);
    localparam logic signed [17:0] LEVEL_NEG_LO = 18'(-LVL_LO);
    localparam logic signed [17:0] LEVEL_POS_LO = 18'(LVL_LO);
    localparam logic signed [17:0] LEVEL_POS_HI = 18'(LVL_HI);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [PW-1:0]      phase;
    logic [FW-1:0]      flush_cnt;
    logic               stop_pending;
    logic               phase_first;
    logic               phase_last;
    logic               flush_end;
    logic               take;
    logic               slot_miss;
    logic               enter_run;
    logic               enter_flush;
    logic signed [17:0] level;

    assign phase_first = (phase == '0);
    assign phase_last  = (phase == PHASE_LAST);
    assign flush_end   = (flush_cnt == '0);

    always_comb begin
        level = '0;
        case (sym_in)
            2'b00:   level = LEVEL_NEG_HI;
            2'b01:   level = LEVEL_NEG_LO;
            2'b10:   level = LEVEL_POS_LO;
            default: level = LEVEL_POS_HI;
        endcase
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_next  = state;
        sym_ready   = 1'b0;
        busy        = 1'b0;
        take        = 1'b0;
        slot_miss   = 1'b0;
        enter_run   = 1'b0;
        enter_flush = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    enter_run  = 1'b1;
                end
            end
            RUN: begin
                busy      = 1'b1;
                sym_ready = phase_first;
                take      = phase_first && sym_valid;
                slot_miss = phase_first && !sym_valid;
                // A stop landing on the last phase still counts for this period.
                if (phase_last && (stop_pending || stop)) begin
                    state_next  = FLUSH;
                    enter_flush = 1'b1;
                end
            end
            FLUSH: begin
                busy = 1'b1;
                if (flush_end) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase        <= '0;
            flush_cnt    <= '0;
            stop_pending <= 1'b0;
            x_out        <= '0;
            sym_strobe   <= 1'b0;
            done         <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            x_out      <= take ? level : '0;
            sym_strobe <= take;
            done       <= (state == FLUSH) && flush_end;

            if (state == RUN) begin
                phase <= phase_last ? '0 : phase + PW'(1);
            end else begin
                phase <= '0;
            end

            if (enter_flush) begin
                flush_cnt <= FLUSH_LOAD;
            end else if ((state == FLUSH) && !flush_end) begin
                flush_cnt <= flush_cnt - FW'(1);
            end

            case (state)
                IDLE:    if (enter_run) stop_pending <= stop;
                RUN:     if (stop) stop_pending <= 1'b1;
                FLUSH:   if (flush_end) stop_pending <= 1'b0;
                default: stop_pending <= 1'b0;
            endcase

            if (enter_run) begin
                underrun <= 1'b0;
            end else if (slot_miss) begin
                underrun <= 1'b1;
            end
        end
    end

`ifdef TX_UNDERRUN_CNT_EN
    logic [7:0] miss_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            miss_cnt <= '0;
        end else if (enter_run) begin
            miss_cnt <= '0;
        end else if (slot_miss && (miss_cnt != '1)) begin
            miss_cnt <= miss_cnt + 8'd1;
        end
    end

    assign underrun_cnt = miss_cnt;
`else
    assign underrun_cnt = '0;
`endif

endmodule
